psa_pipe_adder: RTL and testbench

- Parametrised, pipelined parallel sub-word adder/subtractor for the datapath ALU (PADDSB-class operations).
- Splits a DATA_W operand into LANES independent signed lanes of LANE_W bits; no carry crosses a lane boundary.
- Supports add/sub, wrap/saturate, per-lane signed overflow flags, and valid/ready handshakes on both sides.
- Two-stage pipeline with back-pressure, so it can sit between the decode operand latch and the writeback mux.

---
 rtl/psa_pkg.sv | 27 ++
 rtl/psa_pipe_adder_lane.sv | 36 +++
 rtl/psa_pipe_adder.sv | 144 ++++++++++++++
 tb/tb_psa_pipe_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// Shared constants, types and helpers for the pipelined sub-word adder.
package psa_pkg;

  localparam int LANE_W_DEF = 4;
  localparam int LANES_DEF  = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Total operand width for a given lane geometry.
  function automatic int data_w(input int lane_w, input int lanes);
    return lane_w * lanes;
  endfunction

  // Most positive signed lane value, 0111..1 (truncate to the lane width at use).
  function automatic logic [31:0] sat_pos(input int lane_w);
    return (32'd1 << (lane_w - 1)) - 32'd1;
  endfunction

  // Most negative signed lane value, 1000..0 (truncate to the lane width at use).
  function automatic logic [31:0] sat_neg(input int lane_w);
    return 32'd1 << (lane_w - 1);
  endfunction

endpackage

// File: rtl/psa_pipe_adder_lane.sv
// One combinational lane: LANE_W-bit signed add/sub with overflow detect.
// o_sat_val is the value the lane clamps to if it overflows; its sign follows A,
// because a signed overflow can only push the result away from A's sign.
module psa_lane
  import psa_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  input  logic              i_sub,
  output logic [LANE_W-1:0] o_raw,
  output logic              o_ov,
  output logic [LANE_W-1:0] o_sat_val
);

  localparam logic [LANE_W-1:0] SAT_POS = LANE_W'(sat_pos(LANE_W));
  localparam logic [LANE_W-1:0] SAT_NEG = LANE_W'(sat_neg(LANE_W));

  op_t               w_op;
  logic [LANE_W-1:0] w_b_eff;
  logic [LANE_W-1:0] w_cin;

  assign w_op    = i_sub ? OP_SUB : OP_ADD;
  assign w_b_eff = (w_op == OP_SUB) ? ~i_b : i_b;
  assign w_cin   = {{(LANE_W-1){1'b0}}, i_sub};

  // Carry out of the lane is dropped by the LANE_W-bit result width.
  assign o_raw = i_a + w_b_eff + w_cin;

  assign o_ov = ( o_raw[LANE_W-1] & ~i_a[LANE_W-1] & ~w_b_eff[LANE_W-1]) |
                (~o_raw[LANE_W-1] &  i_a[LANE_W-1] &  w_b_eff[LANE_W-1]);

  assign o_sat_val = i_a[LANE_W-1] ? SAT_NEG : SAT_POS;

endmodule

// File: rtl/psa_pipe_adder.sv
// Two-stage pipelined parallel sub-word adder/subtractor with valid/ready on
// both sides. Optional saturation statistics counter: define PSA_SAT_STATS_EN
// to add the clr_stats input and the 16-bit sat_cnt output.
module psa_pipe_adder
  import psa_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W*LANES-1:0] a,
  input  logic [LANE_W*LANES-1:0] b,
  input  logic                    sub,
  input  logic                    sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] sum,
  output logic [LANES-1:0]        ovfl
`ifdef PSA_SAT_STATS_EN
  ,
  input  logic                    clr_stats,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int DATA_W = data_w(LANE_W, LANES);

  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_sat_val;
  logic [LANES-1:0]  w_ov;
  logic [DATA_W-1:0] w_s2_res;
  logic              w_s1_load;
  logic              w_s2_load;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_raw;
  logic [DATA_W-1:0] r_s1_sat_val;
  logic [LANES-1:0]  r_s1_ov;
  logic              r_s1_sat;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_sum;
  logic [LANES-1:0]  r_ovfl;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psa_lane #(.LANE_W(LANE_W)) u_lane (
      .i_a       (a[g*LANE_W +: LANE_W]),
      .i_b       (b[g*LANE_W +: LANE_W]),
      .i_sub     (sub),
      .o_raw     (w_raw[g*LANE_W +: LANE_W]),
      .o_ov      (w_ov[g]),
      .o_sat_val (w_sat_val[g*LANE_W +: LANE_W])
    );

    assign w_s2_res[g*LANE_W +: LANE_W] = (r_s1_sat & r_s1_ov[g]) ?
                                          r_s1_sat_val[g*LANE_W +: LANE_W] :
                                          r_s1_raw[g*LANE_W +: LANE_W];
  end

  assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign w_s1_load = in_valid & in_ready;

  // Stage 1: capture per-lane raw result, overflow and clamp value on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_raw     <= '0;
      r_s1_sat_val <= '0;
      r_s1_ov      <= '0;
      r_s1_sat     <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid   <= 1'b1;
      r_s1_raw     <= w_raw;
      r_s1_sat_val <= w_sat_val;
      r_s1_ov      <= w_ov;
      r_s1_sat     <= sat;
    end else if (w_s2_load) begin
      r_s1_valid   <= 1'b0;
    end
  end

  // Stage 2: apply saturation and hold the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_ovfl     <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_sum      <= w_s2_res;
      r_ovfl     <= r_s1_ov;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign ovfl      = r_ovfl;

`ifdef PSA_SAT_STATS_EN
  logic        r_s2_sat;
  logic [15:0] r_sat_cnt;
  logic [16:0] w_hits;
  logic [16:0] w_cnt_sum;

  // Track the sat mode of the beat sitting in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_sat <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_sat <= r_s1_sat;
    end
  end

  // Number of lanes of the current output beat that were clamped.
  always_comb begin
    w_hits = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hits = w_hits + 17'(r_ovfl[i] & r_s2_sat);
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_cnt} + w_hits;

  // Saturating clamp counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (clr_stats) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid & out_ready) begin
      r_sat_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_psa_pipe_adder.sv
module tb_psa_pipe_adder;

  localparam int LW = 4;
  localparam int NL = 4;
  localparam int DW = LW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          sub;
  logic          sat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic [NL-1:0] ovfl;
`ifdef PSA_SAT_STATS_EN
  logic          clr_stats;
  logic [15:0]   sat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psa_pipe_adder #(.LANE_W(LW), .LANES(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovfl      (ovfl)
`ifdef PSA_SAT_STATS_EN
    ,
    .clr_stats (clr_stats),
    .sat_cnt   (sat_cnt)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sat;
    logic [15:0] e_sum;
    logic [3:0]  e_ovfl;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  o;
    int          hits;
  } exp_t;

  vec_t vecs[10];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: true signed arithmetic per lane, then range check and clamp.
  function automatic void ref_beat(input logic [15:0] ra, input logic [15:0] rb,
                                   input logic rsub, input logic rsat,
                                   output logic [15:0] rs, output logic [3:0] ro,
                                   output int rhits);
    rs = '0;
    ro = '0;
    rhits = 0;
    for (int i = 0; i < NL; i++) begin
      int va;
      int vb;
      int r;
      va = int'(ra[i*4 +: 4]);
      vb = int'(rb[i*4 +: 4]);
      if (va >= 8) va -= 16;
      if (vb >= 8) vb -= 16;
      r = rsub ? (va - vb) : (va + vb);
      ro[i] = (r > 7) || (r < -8);
      if (rsat && r > 7) r = 7;
      if (rsat && r < -8) r = -8;
      if (ro[i] && rsat) rhits++;
      rs[i*4 +: 4] = r[3:0];
    end
  endfunction

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; sat = v.sat;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("vec_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("vec_lat1_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("vec_lat2_valid", out_valid, 1);
    chk("vec_sum", sum, v.e_sum);
    chk("vec_ovfl", ovfl, v.e_ovfl);
    @(posedge clk);
  endtask

  logic [15:0] bp_a[5];
  logic [15:0] bp_b[5];
  logic [15:0] bp_exp[5];
  logic [3:0]  bp_o;
  int          bp_h;
  int          in_idx;
  int          out_idx;
  int          gaps;
  bit          started;
  logic [15:0] held;
  bit          prev_stall;
  logic [15:0] prev_sum;
  logic [3:0]  prev_ovfl;
  exp_t        e;
  int          exp_cnt;

  initial begin
    vecs[0] = '{16'h7183, 16'h118F, 1'b0, 1'b0, 16'h8202, 4'b1010};
    vecs[1] = '{16'h7183, 16'h118F, 1'b0, 1'b1, 16'h7282, 4'b1010};
    vecs[2] = '{16'h8000, 16'h1000, 1'b1, 1'b1, 16'h8000, 4'b1000};
    vecs[3] = '{16'h8000, 16'h1000, 1'b1, 1'b0, 16'h7000, 4'b1000};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFF0, 4'b0000};
    vecs[5] = '{16'h0000, 16'h8888, 1'b1, 1'b1, 16'h7777, 4'b1111};
    vecs[6] = '{16'h0000, 16'h8888, 1'b1, 1'b0, 16'h8888, 4'b1111};
    vecs[7] = '{16'h8888, 16'h8888, 1'b0, 1'b1, 16'h8888, 4'b1111};
    vecs[8] = '{16'h8888, 16'h8888, 1'b0, 1'b0, 16'h0000, 4'b1111};
    vecs[9] = '{16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
`ifdef PSA_SAT_STATS_EN
    clr_stats = 1'b0;
`endif
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_ovfl", ovfl, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Back-pressure: five beats offered while the consumer stalls, then released.
    bp_a[0] = 16'h7183; bp_b[0] = 16'h118F;
    bp_a[1] = 16'h1234; bp_b[1] = 16'h4321;
    bp_a[2] = 16'h8888; bp_b[2] = 16'h7777;
    bp_a[3] = 16'h5A5A; bp_b[3] = 16'h3C3C;
    bp_a[4] = 16'hF00F; bp_b[4] = 16'h8118;
    for (int i = 0; i < 5; i++) ref_beat(bp_a[i], bp_b[i], 1'b0, 1'b1, bp_exp[i], bp_o, bp_h);
    in_idx = 0; out_idx = 0; gaps = 0; started = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (in_idx < 5);
      if (in_idx < 5) begin
        a = bp_a[in_idx]; b = bp_b[in_idx]; sub = 1'b0; sat = 1'b1;
      end
      #1;
      if (cyc == 2) held = sum;
      if (cyc >= 3 && cyc <= 5) chk("bp_sum_hold", sum, held);
      if (cyc == 5) begin
        chk("bp_accepts", in_idx, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_stall", out_valid, 1);
        chk("bp_held_first", held, bp_exp[0]);
      end
      if (out_valid && out_ready) begin
        chk("bp_sum_order", sum, bp_exp[out_idx]);
        out_idx++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
    end
    chk("bp_count", out_idx, 5);
    chk("bp_gaps", gaps, 0);

    // Asynchronous reset with both stages occupied.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0;
      a = 16'h1111; b = 16'h2222; sub = 1'b0; sat = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
`ifdef PSA_SAT_STATS_EN
    #1 chk("midrst_sat_cnt", sat_cnt, 0);
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("postrst_idle_valid", out_valid, 0);
    end
    apply_vec(vecs[0]);

    // Randomized traffic against the queue model.
    q.delete();
    prev_stall = 1'b0; prev_sum = '0; prev_ovfl = '0; exp_cnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_data", {sum, ovfl}, {prev_sum, prev_ovfl});
      end
      chk("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_sum", sum, e.s);
          chk("rnd_ovfl", ovfl, e.o);
          exp_cnt = (exp_cnt + e.hits > 65535) ? 65535 : exp_cnt + e.hits;
        end
      end
      if (in_valid && in_ready) begin
        ref_beat(a, b, sub, sat, e.s, e.o, e.hits);
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_ovfl  = ovfl;
      @(posedge clk);
    end

    for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_sum", sum, e.s);
        chk("drain_ovfl", ovfl, e.o);
        exp_cnt = (exp_cnt + e.hits > 65535) ? 65535 : exp_cnt + e.hits;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

`ifdef PSA_SAT_STATS_EN
    chk("stats_sat_cnt", sat_cnt, exp_cnt);
    clr_stats = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_stats = 1'b0;
    #1 chk("stats_clear", sat_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
